// File: rtl/seg_pair_to_bin.sv
// Two-digit active-low 7-segment readback: recovers the binary value 0..99 and the
// blank state once the segment pattern has been steady for STABLE_CYCLES samples.
module seg_pair_to_bin #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [0:6] display1,
   input  logic [0:6] display2,
   output logic [6:0] X,
   output logic       EN,
   output logic       valid,
   output logic       err
);

   localparam logic [3:0]  STABLE  = 4'(STABLE_CYCLES);
   localparam logic [13:0] BLANK_2 = {7'b1111111, 7'b1111111};

   typedef enum logic {SETTLING = 1'b0, LOCKED = 1'b1} state_t;

   // Returns {legal_digit, blank, digit}; an illegal pattern has both flags low.
   function automatic logic [5:0] seg_decode(input logic [0:6] seg);
      case (seg)
         7'b0000001: seg_decode = {2'b10, 4'd0};
         7'b1001111: seg_decode = {2'b10, 4'd1};
         7'b0010010: seg_decode = {2'b10, 4'd2};
         7'b0000110: seg_decode = {2'b10, 4'd3};
         7'b1001100: seg_decode = {2'b10, 4'd4};
         7'b0100100: seg_decode = {2'b10, 4'd5};
         7'b0100000: seg_decode = {2'b10, 4'd6};
         7'b0001111: seg_decode = {2'b10, 4'd7};
         7'b0000000: seg_decode = {2'b10, 4'd8};
         7'b0000100: seg_decode = {2'b10, 4'd9};
         7'b1111111: seg_decode = {2'b01, 4'd0};
         default:    seg_decode = {2'b00, 4'd0};
      endcase
   endfunction

   logic [13:0] pair_s;
   logic [13:0] in_q_r;
   logic [3:0]  cnt_r;
   logic [3:0]  cnt_next_s;
   state_t      state_r;
   logic        commit_s;
   logic [5:0]  dec_u_s;
   logic [5:0]  dec_t_s;
   logic [6:0]  value_s;
   logic [6:0]  x_r;
   logic        en_r;
   logic        valid_r;
   logic        err_r;

   assign pair_s  = {display2, display1};
   assign dec_u_s = seg_decode(in_q_r[6:0]);
   assign dec_t_s = seg_decode(in_q_r[13:7]);
   assign value_s = ({3'b000, dec_t_s[3:0]} * 7'd10) + {3'b000, dec_u_s[3:0]};

   // Stability counter: saturates at STABLE while the sampled pair is unchanged.
   always_comb begin
      cnt_next_s = 4'd0;
      if (pair_s == in_q_r) begin
         if (cnt_r >= STABLE) begin
            cnt_next_s = STABLE;
         end else begin
            cnt_next_s = cnt_r + 4'd1;
         end
      end else begin
         cnt_next_s = 4'd0;
      end
   end

   // Commit happens only on the SETTLING->LOCKED edge, so a held pattern never recommits.
   assign commit_s = (state_r == SETTLING) && (cnt_next_s == STABLE);

   // Sample register, lock state and registered commit outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_q_r  <= BLANK_2;
         cnt_r   <= 4'd0;
         state_r <= SETTLING;
         x_r     <= 7'd0;
         en_r    <= 1'b0;
         valid_r <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         in_q_r  <= pair_s;
         cnt_r   <= cnt_next_s;
         state_r <= (cnt_next_s == STABLE) ? LOCKED : SETTLING;
         valid_r <= 1'b0;
         err_r   <= 1'b0;
         if (commit_s) begin
            if (dec_u_s[5] && dec_t_s[5]) begin
               x_r     <= value_s;
               en_r    <= 1'b1;
               valid_r <= 1'b1;
            end else if (dec_u_s[4] && dec_t_s[4]) begin
               x_r     <= 7'd0;
               en_r    <= 1'b0;
               valid_r <= 1'b1;
            end else begin
               err_r   <= 1'b1;
            end
         end else begin
            x_r  <= x_r;
            en_r <= en_r;
         end
      end
   end

   assign X     = x_r;
   assign EN    = en_r;
   assign valid = valid_r;
   assign err   = err_r;

endmodule
